// File: rtl/joy_db15_tx.sv
// joy_db15_tx
// Device-side end of the DB15 serial joystick link. It mimics the adapter
// board's chained parallel-in/serial-out shift registers. Two 16-bit button
// words are loaded while the host holds JOY_LOAD low. They are then shifted
// out on JOY_DATA, LSB first and active-low, one bit per JOY_CLK rising edge.
// The host pins are asynchronous and are synchronized into the clk domain.

module joy_db15_tx #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 48000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] joystick1,
   input  logic [15:0] joystick2,
   input  logic        JOY_CLK,
   input  logic        JOY_LOAD,
   output logic        JOY_DATA,
   output logic [5:0]  bit_count,
   output logic        frame_done,
   output logic        link_active
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      MODE_LOAD,
      MODE_SHIFT
   } mode_t;

   logic [SYNC_STAGES-1:0] clkSync_q;
   logic [SYNC_STAGES-1:0] loadSync_q;
   logic                   clkPrev_q;
   logic                   loadPrev_q;
   logic                   clkSynced;
   logic                   loadSynced;
   logic                   clkRise;
   logic                   loadFall;
   mode_t                  mode;

   logic [31:0]            loadWord;
   logic [31:0]            shiftReg_q;
   logic [31:0]            shiftReg_d;
   logic [5:0]             bitCount_q;
   logic [5:0]             bitCount_d;
   logic                   frameDone_q;
   logic                   frameDone_d;

   logic [TW-1:0]          timeoutCnt_q;
   logic [TW-1:0]          timeoutCnt_d;
   logic                   linkSeen_q;
   logic                   linkSeen_d;
   logic                   timedOut;

   // Synchronizer chains (preset high so reset never looks like a pressed
   // load or a clock edge), plus the previous-value registers used for
   // edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         clkSync_q  <= '1;
         loadSync_q <= '1;
         clkPrev_q  <= 1'b1;
         loadPrev_q <= 1'b1;
      end else begin
         clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], JOY_CLK};
         loadSync_q <= {loadSync_q[SYNC_STAGES-2:0], JOY_LOAD};
         clkPrev_q  <= clkSynced;
         loadPrev_q <= loadSynced;
      end
   end

   assign clkSynced  = clkSync_q[SYNC_STAGES-1];
   assign loadSynced = loadSync_q[SYNC_STAGES-1];
   assign clkRise    = clkSynced & ~clkPrev_q;
   assign loadFall   = ~loadSynced & loadPrev_q;
   assign mode       = loadSynced ? MODE_SHIFT : MODE_LOAD;
   assign timedOut   = (timeoutCnt_q == TW'(TIMEOUT_CYCLES));

   // Parallel-load image: each word is bit-reversed and inverted so that
   // bit 0 of joystick1 lands in the MSB and leaves first, active-low.
   always_comb begin
      loadWord = '1;
      for (int i = 0; i < 16; i++) begin
         loadWord[31-i] = ~joystick1[i];
         loadWord[15-i] = ~joystick2[i];
      end
   end

   // Next state of the shift register and bit counter. While load is low,
   // the inputs stay transparent and any clock edge is discarded. A
   // timed-out link always shows all ones so no button reads as pressed.
   always_comb begin
      shiftReg_d  = shiftReg_q;
      bitCount_d  = bitCount_q;
      frameDone_d = 1'b0;
      case (mode)
         MODE_LOAD: begin
            shiftReg_d = loadWord;
            bitCount_d = '0;
         end
         MODE_SHIFT: begin
            if (clkRise) begin
               shiftReg_d = {shiftReg_q[30:0], 1'b1};
               if (bitCount_q < 6'd32) begin
                  bitCount_d  = bitCount_q + 6'd1;
                  frameDone_d = (bitCount_q == 6'd31);
               end
            end
         end
         default: begin
            shiftReg_d = '1;
         end
      endcase
      if (timedOut) begin
         shiftReg_d = '1;
      end
   end

   // Next state of the link watchdog: it restarts on every load falling edge
   // and otherwise counts up to the timeout, where it sticks.
   always_comb begin
      timeoutCnt_d = timeoutCnt_q;
      linkSeen_d   = linkSeen_q;
      if (loadFall) begin
         timeoutCnt_d = '0;
         linkSeen_d   = 1'b1;
      end else if (!timedOut) begin
         timeoutCnt_d = timeoutCnt_q + TW'(1);
      end
   end

   // Register the shifter, the counters and the frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         shiftReg_q   <= '1;
         bitCount_q   <= '0;
         frameDone_q  <= 1'b0;
         timeoutCnt_q <= '0;
         linkSeen_q   <= 1'b0;
      end else begin
         shiftReg_q   <= shiftReg_d;
         bitCount_q   <= bitCount_d;
         frameDone_q  <= frameDone_d;
         timeoutCnt_q <= timeoutCnt_d;
         linkSeen_q   <= linkSeen_d;
      end
   end

   assign JOY_DATA    = shiftReg_q[31];
   assign bit_count   = bitCount_q;
   assign frame_done  = frameDone_q;
   assign link_active = linkSeen_q & ~timedOut;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx
// Drives two copies of joy_db15_tx from the same host pins. Copy A uses the
// default watchdog, and copy B uses a 100-cycle watchdog so that a timeout
// can be seen quickly. A stream-level model predicts every output on every
// cycle. Host-side sampled bit streams are also checked against
// hand-computed words.

module tb_joy_db15_tx;

   localparam int S  = 2;
   localparam int TA = 48000;
   localparam int TB = 100;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic [15:0] joy1    = 16'h0000;
   logic [15:0] joy2    = 16'h0000;
   logic        pinClk  = 1'b0;
   logic        pinLoad = 1'b1;

   logic        dataA, fdA, laA;
   logic        dataB, fdB, laB;
   logic [5:0]  bcA, bcB;

   int vectors = 0;
   int errors  = 0;
   int fdSeen  = 0;

   logic        modelValid = 1'b0;
   logic        clkHist [S];
   logic        loadHist [S];
   logic        prevClk, prevLoad;
   logic [15:0] lj1, lj2;
   int          mCount;
   logic        mFd;
   int          mTo [2];
   logic        mSeen [2];
   logic        mForced [2];
   int          tLimit [2];

   logic [31:0] stream;
   logic [3:0]  extra;
   logic        b;
   int          fdBase;

   joy_db15_tx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TA)) dutA (
      .clk(clk), .reset(rst), .joystick1(joy1), .joystick2(joy2),
      .JOY_CLK(pinClk), .JOY_LOAD(pinLoad), .JOY_DATA(dataA),
      .bit_count(bcA), .frame_done(fdA), .link_active(laA)
   );

   joy_db15_tx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TB)) dutB (
      .clk(clk), .reset(rst), .joystick1(joy1), .joystick2(joy2),
      .JOY_CLK(pinClk), .JOY_LOAD(pinLoad), .JOY_DATA(dataB),
      .bit_count(bcB), .frame_done(fdB), .link_active(laB)
   );

   // Free-running joystick clock, 10 time units per period.
   always #5 clk = ~clk;

   // Value the host would read at stream position idx of the latched words.
   function automatic logic streamBit(input int idx);
      if (idx < 16) return ~lj1[idx];
      if (idx < 32) return ~lj2[idx-16];
      return 1'b1;
   endfunction

   // One comparison: it counts the vector and reports any difference.
   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Stream-level model. The pins reach the logic S cycles late. While load
   // is low, the words are latched and the position is rewound. Each clock
   // rise advances the position. The wire shows the bit at that position,
   // unless the watchdog has fired since the last good load.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < S; i++) begin
            clkHist[i]  = 1'b1;
            loadHist[i] = 1'b1;
         end
         prevClk  = 1'b1;
         prevLoad = 1'b1;
         mCount   = 0;
         mFd      = 1'b0;
         for (int k = 0; k < 2; k++) begin
            mTo[k]     = 0;
            mSeen[k]   = 1'b0;
            mForced[k] = 1'b1;
         end
         modelValid = 1'b1;
      end else begin
         logic sClk, sLoad, rise, fall;
         sClk  = clkHist[S-1];
         sLoad = loadHist[S-1];
         rise  = sClk & ~prevClk;
         fall  = ~sLoad & prevLoad;
         mFd   = 1'b0;
         for (int k = 0; k < 2; k++) begin
            if (mTo[k] == tLimit[k]) mForced[k] = 1'b1;
            else if (!sLoad) mForced[k] = 1'b0;
         end
         if (!sLoad) begin
            lj1    = joy1;
            lj2    = joy2;
            mCount = 0;
         end else if (rise && mCount < 32) begin
            mCount = mCount + 1;
            if (mCount == 32) mFd = 1'b1;
         end
         for (int k = 0; k < 2; k++) begin
            if (fall) begin
               mTo[k]   = 0;
               mSeen[k] = 1'b1;
            end else if (mTo[k] < tLimit[k]) begin
               mTo[k] = mTo[k] + 1;
            end
         end
         prevClk  = sClk;
         prevLoad = sLoad;
         for (int i = S-1; i > 0; i--) begin
            clkHist[i]  = clkHist[i-1];
            loadHist[i] = loadHist[i-1];
         end
         clkHist[0]  = pinClk;
         loadHist[0] = pinLoad;
      end
   end

   // Compare both copies against the model shortly after every clock edge.
   always @(posedge clk) begin
      #2;
      if (modelValid) begin
         checkOutput("A.JOY_DATA", dataA, mForced[0] ? 1 : streamBit(mCount));
         checkOutput("A.bit_count", bcA, mCount);
         checkOutput("A.frame_done", fdA, mFd);
         checkOutput("A.link_active", laA, (mSeen[0] && mTo[0] < TA) ? 1 : 0);
         checkOutput("B.JOY_DATA", dataB, mForced[1] ? 1 : streamBit(mCount));
         checkOutput("B.bit_count", bcB, mCount);
         checkOutput("B.frame_done", fdB, mFd);
         checkOutput("B.link_active", laB, (mSeen[1] && mTo[1] < TB) ? 1 : 0);
      end
      if (fdA) fdSeen++;
   end

   // Drive the host pins on a falling clk edge and hold them for a number of cycles.
   task automatic applyStimulus(input logic ld, input logic ck, input int holdCycles);
      @(negedge clk);
      pinLoad = ld;
      pinClk  = ck;
      repeat (holdCycles - 1) @(negedge clk);
   endtask

   // Change the button words away from the sampling edge.
   task automatic setButtons(input logic [15:0] a, input logic [15:0] c);
      @(negedge clk);
      joy1 = a;
      joy2 = c;
   endtask

   // Hold load low for 8 cycles, then give the release time to settle.
   task automatic loadPulse();
      applyStimulus(1'b0, 1'b0, 8);
      applyStimulus(1'b1, 1'b0, 8);
   endtask

   // Read the current bit as the host would, then give one 8-high/8-low clock.
   task automatic clockBit(output logic bitOut);
      bitOut = dataA;
      applyStimulus(1'b1, 1'b1, 8);
      applyStimulus(1'b1, 1'b0, 8);
   endtask

   // Directed scenarios, each closed with hand-computed expectations.
   initial begin
      tLimit[0] = TA;
      tLimit[1] = TB;

      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("idle JOY_DATA", dataA, 1);
      checkOutput("idle bit_count", bcA, 0);
      checkOutput("idle link_active", laA, 0);
      checkOutput("idle frame_done count", fdSeen, 0);

      setButtons(16'h0001, 16'h8000);
      fdBase = fdSeen;
      loadPulse();
      for (int i = 0; i < 32; i++) begin
         clockBit(b);
         stream[i] = b;
      end
      checkOutput("frame1 stream", stream, 32'h7FFFFFFE);
      checkOutput("frame1 bit_count", bcA, 32);
      checkOutput("frame1 frame_done pulses", fdSeen - fdBase, 1);
      clockBit(b);
      checkOutput("frame1 fill bit", b, 1);

      setButtons(16'hA5C3, 16'h3C5A);
      fdBase = fdSeen;
      loadPulse();
      for (int i = 0; i < 32; i++) begin
         clockBit(b);
         stream[i] = b;
      end
      for (int i = 0; i < 4; i++) begin
         clockBit(b);
         extra[i] = b;
      end
      checkOutput("frame2 stream", stream, 32'hC3A55A3C);
      checkOutput("frame2 extra bits", extra, 4'hF);
      checkOutput("frame2 bit_count", bcA, 32);
      checkOutput("frame2 frame_done pulses", fdSeen - fdBase, 1);

      fdBase = fdSeen;
      loadPulse();
      for (int i = 0; i < 10; i++) clockBit(b);
      checkOutput("abort pre bit_count", bcA, 10);
      setButtons(16'h0002, 16'h3C5A);
      loadPulse();
      checkOutput("abort bit_count", bcA, 0);
      clockBit(b);
      checkOutput("abort first bit", b, 1);
      clockBit(b);
      checkOutput("abort second bit", b, 0);
      checkOutput("abort frame_done pulses", fdSeen - fdBase, 0);

      applyStimulus(1'b0, 1'b0, 8);
      applyStimulus(1'b0, 1'b1, 8);
      checkOutput("held-load bit_count", bcA, 0);
      setButtons(16'h0000, 16'h0000);
      repeat (4) @(negedge clk);
      checkOutput("held-load live data released", dataA, 1);
      setButtons(16'h0001, 16'h0000);
      repeat (4) @(negedge clk);
      checkOutput("held-load live data pressed", dataA, 0);
      applyStimulus(1'b0, 1'b0, 8);
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b1, 8);
      checkOutput("same-cycle edge bit_count", bcA, 0);
      applyStimulus(1'b1, 1'b0, 8);
      checkOutput("same-cycle edge data", dataA, 0);
      checkOutput("same-cycle edge bit_count after", bcA, 0);

      applyStimulus(1'b0, 1'b0, 8);
      applyStimulus(1'b1, 1'b0, 42);
      checkOutput("B link_active before timeout", laB, 1);
      checkOutput("B data before timeout", dataB, 0);
      repeat (70) @(negedge clk);
      checkOutput("B link_active after timeout", laB, 0);
      checkOutput("B data after timeout", dataB, 1);
      checkOutput("A link_active still up", laA, 1);
      loadPulse();
      checkOutput("B link_active restored", laB, 1);
      checkOutput("B data restored", dataB, 0);

      loadPulse();
      for (int i = 0; i < 5; i++) clockBit(b);
      applyStimulus(1'b1, 1'b1, 3);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("reset JOY_DATA", dataA, 1);
      checkOutput("reset bit_count", bcA, 0);
      checkOutput("reset frame_done", fdA, 0);
      checkOutput("reset link_active", laA, 0);
      checkOutput("reset B link_active", laB, 0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 8);
      checkOutput("post-reset bit_count", bcA, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side end of the DB15 serial joystick link. It behaves like the adapter board's chained parallel-in/serial-out shift registers.
- It takes two 16-bit button words and drives them out on JOY_DATA under control of the host-generated JOY_LOAD and JOY_CLK.
- Uses: loopback and bench stimulus for the DB15 reader, and an FPGA-based adapter build.
- Runs in the 40-50 MHz joystick clock domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on JOY_CLK and JOY_LOAD (minimum 2).
- TIMEOUT_CYCLES, 48000, clk cycles without a JOY_LOAD low pulse before link_active drops (1 ms at 48 MHz).

Ports:
- clk  in  1  joystick clock, 40-50 MHz.
- reset  in  1  synchronous, active-high.
- joystick1  in  16  player 1 buttons, active-high. Bit map: [15:12]=FEDC, [11:10]=BA, [9:4]=spare/extra, [3:0]=UDLR.
- joystick2  in  16  player 2 buttons, same map.
- JOY_CLK  in  1  host shift clock, async to clk. Data advances on its rising edge.
- JOY_LOAD  in  1  host parallel-load, active-low, async to clk.
- JOY_DATA  out  1  serial data, active-low on the wire (0 = pressed).
- bit_count  out  6  number of shifts since the last load, 0..32, saturating.
- frame_done  out  1  one-cycle pulse when the 32nd shift completes.
- link_active  out  1  1 while load pulses arrive within TIMEOUT_CYCLES.

Behaviour:
- Reset values:
  - shift register = all ones, so JOY_DATA = 1 (released).
  - bit_count = 0, frame_done = 0, link_active = 0.
  - timeout counter = 0.
  - synchronizer chains preset to 1.
- Synchronization and edge detection:
  - JOY_CLK and JOY_LOAD each pass through SYNC_STAGES flip-flops.
  - A rising-edge detect on synced JOY_CLK uses one extra register.
- Shift register, 32 bits, sr[31:0]. JOY_DATA = sr[31].
- State LOAD, entered while synced JOY_LOAD = 0:
  - Every clk cycle, sr <= {~joystick1[0..15] bit-reversed, ~joystick2[0..15] bit-reversed}.
  - Result: sr[31] = ~joystick1[0], sr[16] = ~joystick1[15], sr[15] = ~joystick2[0], sr[0] = ~joystick2[15].
  - bit_count <= 0.
  - Inputs are transparent while load is held low; the value is frozen on the load rising edge.
- State SHIFT, entered while synced JOY_LOAD = 1:
  - On each detected JOY_CLK rising edge, sr <= {sr[30:0], 1'b1}.
  - The fill bit is 1, matching a serial-in tied high.
  - bit_count increments and saturates at 32.
- frame_done:
  - Pulses for exactly one cycle on the edge that moves bit_count from 31 to 32.
  - Further edges shift out 1s with no further pulse.
- Serial order seen by the host:
  - The first bit is valid right after load, before any clock.
  - Full sequence: j1[0..15], then j2[0..15], then constant 1s.
- Latency: JOY_DATA changes SYNC_STAGES+1 clk cycles after a JOY_CLK rising edge at the pin. The host must hold JOY_CLK high and low for at least SYNC_STAGES+2 clk cycles each.
- Simultaneous events: if synced load is low in the same cycle as a detected clock edge, load wins. The edge is discarded and bit_count stays 0.
- Load is level-sensitive. A load asserted mid-frame aborts the frame immediately: sr is reloaded, bit_count = 0, no frame_done.
- link_active / timeout:
  - Counter clears on every synced load falling edge and increments otherwise, saturating at TIMEOUT_CYCLES.
  - link_active = 1 once a load falling edge has been seen and the counter < TIMEOUT_CYCLES.
  - On timeout, link_active = 0 and sr is forced to all ones. This prevents stuck "pressed" bits if the host disconnects.
- Input changes during SHIFT have no effect until the next load.
- Reset mid-frame returns to the reset values on the next clk edge, regardless of pin state. Pin state is re-sampled through the synchronizers afterward.

Test Plan:
- Reset, then idle with JOY_LOAD=1 and JOY_CLK=0 -> JOY_DATA=1, bit_count=0, frame_done=0, link_active=0 throughout.
- joystick1=16'h0001, joystick2=16'h8000; pulse load low for 8 cycles; apply 32 clock pulses of 8 cycles high / 8 cycles low -> pre-clock JOY_DATA=0, then bits 2..31 = 1, bit 32 = 0, then 1. One frame_done pulse after the 32nd edge; bit_count=32.
- joystick1=16'hA5C3, joystick2=16'h3C5A; full frame, then 4 extra clocks -> the sampled stream equals the active-low LSB-first of each word, and the 4 extra bits are 1. bit_count stays 32; no second frame_done.
- Mid-frame reload: after 10 shifts, load low while joystick1 changes to 16'h0002 -> bit_count=0, the first bit reads 1 and the second reads 0; no frame_done for the aborted frame.
- Load held low while a JOY_CLK edge occurs; also a clock edge arriving on the same synced cycle as load -> no shift, bit_count=0, and JOY_DATA tracks ~joystick1[0] live.
- TIMEOUT_CYCLES=100: one load, then no further loads -> link_active=1 until cycle 100 after the load edge, then 0, with JOY_DATA forced to 1. The next load restores link_active=1. Reset asserted mid-shift -> all outputs at reset values on the following cycle.
